// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: funct3 codes, FSM states, legal write masks, load extension helper
package dmem_access_ctrl_pkg;
  localparam int WORD_SIZE = 4;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, DONE} state_t;
  localparam logic [6:0][3:0] LEGAL_MASKS = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0111, 4'b1111};
  function automatic logic mask_legal(input logic [3:0] m);
    for (int i = 0; i < 7; i++) if (m == LEGAL_MASKS[i]) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d);
    return f3[1] ? d : f3[0] ? {{16{~f3[2] & d[15]}}, d[15:0]} : {{24{~f3[2] & d[7]}}, d[7:0]};
  endfunction
endpackage

// File: rtl/dmem_mask_split.sv
// dmem_mask_split: rem (remaining lanes) -> cur (lanes written this cycle), res (lanes left, 0 on last cycle)
module dmem_mask_split
  import dmem_access_ctrl_pkg::*;
(
  input  logic [3:0] rem,
  output logic [3:0] cur,
  output logic [3:0] res
);
  logic [3:0] low;
  always_comb begin
    low = rem & (~rem + 4'd1);
    cur = mask_legal(rem) ? rem : low;
    res = rem & ~cur;
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: RV32 load/store sequencer; core side i_req/i_we/i_funct3/i_addr/i_wdata -> o_busy/o_done/o_err/o_rdata, memory side o_Addr/o_Wd/o_Wen/o_Ren <- i_Rd
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter bit MISALIGN_EN = 1'b1,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_rdata,
  output logic [ADDR_W-1:0] o_Addr,
  output logic [31:0]       o_Wd,
  output logic [3:0]        o_Wen,
  output logic              o_Ren,
  input  logic [31:0]       i_Rd
);
  state_t state;
  logic word;
  logic [3:0] rem, mask1, size_m, split_in, sp_cur, sp_res;
  logic [1:0] off;
  logic [2:0] f3;
  logic [ADDR_W-1:0] base, req_base, next_base;
  logic [31:0] wdata, asm_lo;
  logic [7:0] req_m;
  logic [63:0] asm_full, asm_sh;
  logic misal, bad;
  always_comb begin
    size_m = i_funct3[1] ? 4'hF : i_funct3[0] ? 4'h3 : 4'h1;
    req_m = {4'b0, size_m} << i_addr[1:0];
    misal = (i_funct3[1:0] == 2'b01 && &i_addr[1:0]) || (i_funct3[1:0] == 2'b10 && |i_addr[1:0]);
    bad = &i_funct3[1:0] || (i_funct3[2] && (i_we || i_funct3[1])) || (misal && !MISALIGN_EN);
    req_base = {i_addr[ADDR_W-1:2], 2'b00};
    next_base = base + ADDR_W'(WORD_SIZE);
    split_in = state == WR ? (|rem ? rem : mask1) : req_m[3:0];
    asm_full = word ? {i_Rd, asm_lo} : {32'b0, i_Rd};
    asm_sh = asm_full >> {off, 3'b000};
  end
  dmem_mask_split u_split (.rem(split_in), .cur(sp_cur), .res(sp_res));
  assign o_busy = state == WR || state == RD || state == RD_WAIT;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      o_done <= 1'b0;
      o_err <= 1'b0;
      o_rdata <= '0;
      o_Addr <= '0;
      o_Wd <= '0;
      o_Wen <= '0;
      o_Ren <= 1'b0;
      word <= 1'b0;
      rem <= '0;
      mask1 <= '0;
      off <= '0;
      f3 <= '0;
      base <= '0;
      wdata <= '0;
      asm_lo <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          o_done <= 1'b0;
          o_err <= 1'b0;
          if (i_req) begin
            f3 <= i_funct3;
            off <= i_addr[1:0];
            base <= req_base;
            wdata <= i_wdata;
            mask1 <= req_m[7:4];
            word <= 1'b0;
            if (bad) begin
              state <= DONE;
              o_done <= 1'b1;
              o_err <= 1'b1;
              o_rdata <= '0;
            end else if (i_we) begin
              state <= WR;
              o_Addr <= req_base;
              o_Wd <= i_wdata << {i_addr[1:0], 3'b000};
              o_Wen <= sp_cur;
              rem <= sp_res;
            end else begin
              state <= RD;
              o_Addr <= req_base;
              o_Ren <= 1'b1;
            end
          end
        end
        WR: begin
          if (|rem) begin
            o_Wen <= sp_cur;
            rem <= sp_res;
          end else if (!word && |mask1) begin
            word <= 1'b1;
            o_Addr <= next_base;
            o_Wd <= wdata >> (6'd32 - {off, 3'b000});
            o_Wen <= sp_cur;
            rem <= sp_res;
          end else begin
            o_Wen <= '0;
            o_done <= 1'b1;
            state <= DONE;
          end
        end
        RD: begin
          o_Ren <= 1'b0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (!word) asm_lo <= i_Rd;
          if (!word && |mask1) begin
            word <= 1'b1;
            o_Addr <= next_base;
            o_Ren <= 1'b1;
            state <= RD;
          end else begin
            o_rdata <= load_ext(f3, asm_sh[31:0]);
            o_done <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequencer between the core's load/store stage and the byte-enabled data memory (4-bit write-enable, synchronous registered read, write has priority over read).
- Accepts one RV32 load/store per handshake and converts it into a legal sequence of memory cycles.
- Splits misaligned accesses across two words and decomposes lane masks the memory cannot write in one cycle.
- Aligns, sign- or zero-extends load data and returns it with a one-cycle done pulse.

Parameters:
- MISALIGN_EN, 1, 1 = split misaligned accesses; 0 = flag them as errors with no memory cycle.
- ADDR_W, 32, core address width; o_Addr arithmetic wraps modulo 2^ADDR_W.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  1  request strobe; accepted only when o_busy=0.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32 funct3: LB000 LH001 LW010 LBU100 LHU101; SB000 SH001 SW010.
- i_addr  in  ADDR_W  byte address.
- i_wdata  in  32  store data, right-justified.
- o_busy  out  1  high while an access is in flight.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  valid with o_done: illegal funct3, or misaligned with MISALIGN_EN=0.
- o_rdata  out  32  extended load data; valid with o_done, held until the next done.
- o_Addr  out  ADDR_W  memory byte address, always word-aligned.
- o_Wd  out  32  lane-positioned write data.
- o_Wen  out  4  byte write enables.
- o_Ren  out  1  read enable.
- i_Rd  in  32  memory read data, valid the cycle after an o_Ren cycle.

Behaviour:
- Reset values: state IDLE; o_busy=0, o_done=0, o_err=0, o_rdata=0, o_Wen=0, o_Ren=0, o_Addr=0, o_Wd=0.
- Reset mid-operation returns to IDLE on the next edge. Memory writes already issued are not undone.
- States: IDLE, WR, RD, RD_WAIT, DONE.
- o_busy=1 in WR, RD and RD_WAIT. A request presented in IDLE or DONE is accepted, so back-to-back requests are allowed. i_req is ignored while busy.
- Byte offset off = i_addr[1:0]. Size is 1, 2 or 4 bytes.
- First-word lane mask: mask0 = size-bit mask shifted left by off, truncated to 4 bits. Any overflow bits form mask1, applied to word base+4.
- Misaligned means a halfword with off=3, or a word with off≠0.
- Illegal funct3, or misaligned with MISALIGN_EN=0: go directly to DONE with o_err=1, o_rdata=0 and no memory cycle.
- Legal single-cycle write masks are exactly 0001, 0010, 0100, 1000, 0011, 0111, 1111.
- Store sequencing:
  - For each nonzero mask (word0, then word1): if the mask is legal, issue one WR cycle with it. Otherwise issue one single-byte WR cycle per set bit, LSB lane first.
  - o_Wd = i_wdata << 8*off for word0, and i_wdata >> 8*(4-off) for word1.
  - After the last WR cycle the block enters DONE.
- Load sequencing:
  - Per word: one RD cycle (o_Ren=1), then RD_WAIT, where i_Rd is captured into a 64-bit assembly buffer at lane position.
  - Word1 reads follow word0.
  - After the last RD_WAIT the result is extracted, extended, registered into o_rdata, and the block enters DONE.
- Latency after the accept edge: aligned store, o_done in cycle 2; aligned load, o_done in cycle 3. Each extra WR cycle adds 1; a second word read adds 2.
- o_Wen=0 and o_Ren=0 in every state other than WR and RD respectively. The two are never asserted together.
- Word1 address = base+4 mod 2^ADDR_W, so 0xFFFFFFFC wraps to 0x0.

Decomposition:
- Shared defines package: funct3 encodings, state encodings, legal-mask constant set, `WORD_SIZE.
- Sub-module dmem_mask_split (combinational): given a remaining mask, outputs the mask for this cycle and the residual mask. The residual is 0 when this is the last cycle for that word.

Test Plan:
- Aligned SW 0xDEADBEEF @0x100 → one WR cycle (o_Wen=1111, o_Addr=0x100), o_done 2 cycles after accept, readback via LW = 0xDEADBEEF.
- SH 0xA1B2 @0x106 → two WR cycles at 0x104: Wen 0100 then 1000, o_Wd lanes [23:16]=0xB2 and [31:24]=0xA1; other bytes unchanged.
- SW 0x11223344 @0x101 → WR 0x100 masks 0010, 0100, 1000, then WR 0x104 mask 0001; LW-split readback = 0x11223344, o_done at cycle 5.
- Memory 0x200=0x80FF7F01: LB @0x203 → 0xFFFFFF80; LBU @0x203 → 0x00000080; LH @0x202 → 0xFFFF80FF; each o_done 3 cycles after accept.
- MISALIGN_EN=0, LW @0x102 → o_done in cycle 1, o_err=1, no o_Ren. funct3=011 load → same response.
- Assert i_rst during the second WR cycle of a split store → outputs return to reset values on the next edge and the first byte remains written. A new request is then accepted from IDLE, and i_req raised while o_busy=1 produces no extra access.
